// File: rtl/stage4_fence_controller.sv
// stage4_fence_controller
// Sequences FENCE.I for the stage4 pipeline. On an ifence from execute it
// holds the pipe, waits for data memory traffic to drain, flushes the
// write-back D$, then invalidates the I$. After that it releases fence_stall
// for one cycle so the hazard unit's rollback (ifence && !fence_stall) can
// flush the pipe and re-fetch. It also records the latency of the last fence.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ifence               FENCE.I valid at execute/mem, held until flushed
//   d_mem_busy           data memory request in flight
//   sb_empty             store buffer empty
//   dcache_flush_req     level request: write back all dirty D$ lines
//   dcache_flush_done    one-cycle pulse: D$ flush complete
//   icache_clear_req     level request: invalidate all I$ lines
//   icache_clear_done    one-cycle pulse: I$ invalidate complete
//   fence_stall          to hazard unit, stalls ex_mem and fetch
//   fence_done           one-cycle pulse on the rollback cycle
//   last_fence_cycles    ifence rise to fence_done, inclusive, saturating
//
// state  | meaning
// IDLE   | no fence; stall follows ifence so the first cycle cannot roll back
// DRAIN  | waiting for memory idle and store buffer empty
// DFLUSH | D$ write-back flush requested
// ICLEAR | I$ invalidate requested (only after the D$ flush completed)
// DONE   | stall released for one cycle, fence_done pulses

module stage4_fence_controller #(
    parameter bit          DCACHE_WB      = 1'b1,
    parameter bit          ICACHE_PRESENT = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ifence,
    input  logic             d_mem_busy,
    input  logic             sb_empty,
    output logic             dcache_flush_req,
    input  logic             dcache_flush_done,
    output logic             icache_clear_req,
    input  logic             icache_clear_done,
    output logic             fence_stall,
    output logic             fence_done,
    output logic [CNT_W-1:0] last_fence_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DFLUSH,
        ICLEAR,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] last_d;
    logic             dreq_q;
    logic             ireq_q;
    logic             done_q;
    logic             in_fence;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ifence) state_d = DRAIN;
            end
            DRAIN: begin
                if (!d_mem_busy && sb_empty) begin
                    if (DCACHE_WB)           state_d = DFLUSH;
                    else if (ICACHE_PRESENT) state_d = ICLEAR;
                    else                     state_d = DONE;
                end
            end
            DFLUSH: begin
                if (dcache_flush_done) begin
                    if (ICACHE_PRESENT) state_d = ICLEAR;
                    else                state_d = DONE;
                end
            end
            ICLEAR: begin
                if (icache_clear_done) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_fence = (state_q == DRAIN) || (state_q == DFLUSH) || (state_q == ICLEAR);

    // run_inc is the count including the current cycle. Adding one more on
    // entry to DONE makes the recorded latency span the ifence-rise cycle
    // through the fence_done cycle inclusive.
    assign run_inc = (run_q == CNT_MAX) ? CNT_MAX : run_q + CNT_ONE;
    assign last_d  = (run_inc == CNT_MAX) ? CNT_MAX : run_inc + CNT_ONE;

    // Outputs are registered from the next state, so they always equal a
    // decode of the current state and drop together with it on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            run_q   <= '0;
            last_q  <= '0;
            dreq_q  <= 1'b0;
            ireq_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dreq_q  <= (state_d == DFLUSH);
            ireq_q  <= (state_d == ICLEAR);
            done_q  <= (state_d == DONE);
            if (state_q == IDLE && state_d == DRAIN) begin
                run_q <= CNT_ONE;
            end else if (in_fence) begin
                run_q <= run_inc;
            end
            if (in_fence && state_d == DONE) begin
                last_q <= last_d;
            end
        end
    end

    assign fence_stall       = ((state_q == IDLE) && ifence) || in_fence;
    assign dcache_flush_req  = dreq_q;
    assign icache_clear_req  = ireq_q;
    assign fence_done        = done_q;
    assign last_fence_cycles = last_q;

endmodule

// File: tb/tb_stage4_fence_controller.sv
module tb_stage4_fence_controller;

    logic        CLK;
    logic        nRST;
    logic        d_mem_busy;
    logic        sb_empty;
    logic        dfd;
    logic        icd;
    logic        ifence_f, ifence_m;
    logic        dreq_f, ireq_f, fs_f, fd_f;
    logic        dreq_m, ireq_m, fs_m, fd_m;
    logic [15:0] last_f, last_m;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string tag;
        int    done_cyc;
        int    last;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    int obs_done, stall_drop, first_dreq, last_dreq, first_ireq;
    bit req_seen;
    logic done_stall;

    stage4_fence_controller u_full (
        .CLK(CLK), .nRST(nRST), .ifence(ifence_f),
        .d_mem_busy(d_mem_busy), .sb_empty(sb_empty),
        .dcache_flush_req(dreq_f), .dcache_flush_done(dfd),
        .icache_clear_req(ireq_f), .icache_clear_done(icd),
        .fence_stall(fs_f), .fence_done(fd_f), .last_fence_cycles(last_f)
    );

    stage4_fence_controller #(.DCACHE_WB(1'b0), .ICACHE_PRESENT(1'b0), .CNT_W(16)) u_min (
        .CLK(CLK), .nRST(nRST), .ifence(ifence_m),
        .d_mem_busy(d_mem_busy), .sb_empty(sb_empty),
        .dcache_flush_req(dreq_m), .dcache_flush_done(dfd),
        .icache_clear_req(ireq_m), .icache_clear_done(icd),
        .fence_stall(fs_m), .fence_done(fd_m), .last_fence_cycles(last_m)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void drive(input int mode, input int c, input bit use_min);
        logic fi;
        fi         = (c == 0);
        d_mem_busy = 1'b0;
        sb_empty   = 1'b1;
        dfd        = 1'b1;
        icd        = 1'b1;
        case (mode)
            2: begin
                fi         = 1'b1;
                d_mem_busy = (c < 6);
                sb_empty   = !(c >= 6 && c < 9);
            end
            3: begin
                dfd = (c == 22);
                icd = (c == 5 || c == 10 || c == 25);
            end
            6: begin
                icd = (c == 70002);
            end
            default: ;
        endcase
        if (use_min) ifence_m = fi;
        else         ifence_f = fi;
    endfunction

    // Called just after a rising edge; returns one cycle after fence_done.
    task automatic run(input int mode, input int budget, input bit use_min);
        logic fs, fd, dr, ir;
        obs_done   = -1;
        stall_drop = 0;
        first_dreq = -1;
        last_dreq  = -1;
        first_ireq = -1;
        req_seen   = 1'b0;
        done_stall = 1'bx;
        for (int c = 0; c < budget; c++) begin
            drive(mode, c, use_min);
            @(negedge CLK);
            if (use_min) begin fs = fs_m; fd = fd_m; dr = dreq_m; ir = ireq_m; end
            else         begin fs = fs_f; fd = fd_f; dr = dreq_f; ir = ireq_f; end
            if (dr) begin
                if (first_dreq < 0) first_dreq = c;
                last_dreq = c;
            end
            if (ir && first_ireq < 0) first_ireq = c;
            if (dr || ir) req_seen = 1'b1;
            if (fd) begin
                obs_done   = c;
                done_stall = fs;
                break;
            end
            if (!fs) stall_drop++;
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        ifence_f   = 1'b0;
        ifence_m   = 1'b0;
        dfd        = 1'b0;
        icd        = 1'b0;
        d_mem_busy = 1'b0;
        sb_empty   = 1'b1;
    endtask

    task automatic score(input logic [15:0] last_obs);
        e = sb_q.pop_front();
        check({e.tag, "_done_cycle"}, obs_done, e.done_cyc);
        check({e.tag, "_last_cycles"}, last_obs, e.last);
        check({e.tag, "_stall_drop"}, stall_drop, 0);
    endtask

    initial begin
        nRST       = 1'b0;
        ifence_f   = 1'b1;
        ifence_m   = 1'b0;
        d_mem_busy = 1'b0;
        sb_empty   = 1'b1;
        dfd        = 1'b0;
        icd        = 1'b0;
        #1;
        check("rst_stall_follows_ifence", fs_f, 1);
        check("rst_dreq", dreq_f, 0);
        check("rst_ireq", ireq_f, 0);
        check("rst_done", fd_f, 0);
        check("rst_last", last_f, 0);
        ifence_f = 1'b0;
        #1;
        check("rst_stall_low", fs_f, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // fastest fence, all handshakes immediate
        sb_q.push_back('{tag: "fast", done_cyc: 4, last: 5});
        run(1, 20, 1'b0);
        score(last_f);
        check("fast_stall_at_done", done_stall, 0);
        check("fast_first_dreq", first_dreq, 2);
        check("fast_first_ireq", first_ireq, 3);

        // drain waits on busy then store buffer
        sb_q.push_back('{tag: "drain", done_cyc: 12, last: 13});
        run(2, 40, 1'b0);
        score(last_f);
        check("drain_first_dreq", first_dreq, 10);

        // slow D$ flush with spurious I$ done pulses
        sb_q.push_back('{tag: "slowflush", done_cyc: 26, last: 27});
        run(3, 60, 1'b0);
        score(last_f);
        check("slowflush_first_ireq", first_ireq, 23);
        check("slowflush_last_dreq", last_dreq, 22);

        // no caches: DRAIN goes straight to DONE
        sb_q.push_back('{tag: "nocache", done_cyc: 2, last: 3});
        run(4, 20, 1'b1);
        score(last_m);
        check("nocache_no_requests", req_seen, 0);

        // reset in the middle of a D$ flush
        ifence_f = 1'b1;
        dfd      = 1'b0;
        icd      = 1'b0;
        @(posedge CLK); #1;
        ifence_f = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midrst_dreq_before", dreq_f, 1);
        #2 nRST = 1'b0;
        #1;
        check("midrst_dreq_async_drop", dreq_f, 0);
        check("midrst_stall_in_reset", fs_f, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midrst_stall_after", fs_f, 0);
        check("midrst_last_cleared", last_f, 0);
        check("midrst_dreq_after", dreq_f, 0);
        @(posedge CLK); #1;

        // very long I$ clear saturates the latency counter
        sb_q.push_back('{tag: "saturate", done_cyc: 70003, last: 65535});
        run(6, 70010, 1'b0);
        score(last_f);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
